// File: rtl/block_detector_stream.sv
// Streaming colour-blob detector. Every accepted pixel is tested against
// NUM_TARGETS colour windows. Each target tracker keeps the bounding box and
// hit count for the current frame, and publishes them when the frame ends.
// Boxes from the previous frame can be drawn onto the forwarded video.

// Per-target tracker: window match, frame accumulators, latched box, perimeter test.
module block_detector_target #(
  parameter int PIX_W   = 24,
  parameter int COORD_W = 12,
  parameter int CNT_W   = 20
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [PIX_W-1:0]   i_pix,
  input  logic [PIX_W-1:0]   i_lo,
  input  logic [PIX_W-1:0]   i_hi,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_upd,    // in-frame beat accepted this cycle
  input  logic               i_clr,    // drop accumulators (new frame / results taken)
  input  logic               i_latch,  // publish accumulators to the box outputs
  output logic [COORD_W-1:0] o_min_x,
  output logic [COORD_W-1:0] o_max_x,
  output logic [COORD_W-1:0] o_min_y,
  output logic [COORD_W-1:0] o_max_y,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_valid,
  output logic               o_perim
);
  localparam int CW = PIX_W / 3;

  logic               w_hit;
  logic               w_first;
  logic [CNT_W-1:0]   w_cnt_b;
  logic               r_seen;
  logic [COORD_W-1:0] r_minx, r_maxx, r_miny, r_maxy;
  logic [CNT_W-1:0]   r_cnt;

  // Pixel hits when every component lies inside [lo, hi]; lo>hi never matches.
  always_comb begin
    w_hit = 1'b1;
    for (int c = 0; c < 3; c++)
      if (i_pix[c*CW +: CW] < i_lo[c*CW +: CW] || i_pix[c*CW +: CW] > i_hi[c*CW +: CW])
        w_hit = 1'b0;
  end

  // A clear in the same cycle as a hit makes this hit the first of the new frame.
  assign w_first = i_clr || !r_seen;
  assign w_cnt_b = i_clr ? '0 : r_cnt;

  // Running min/max and saturating hit count over the current frame.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_seen <= 1'b0;
      r_cnt  <= '0;
      r_minx <= '0;
      r_maxx <= '0;
      r_miny <= '0;
      r_maxy <= '0;
    end else if (i_upd && w_hit) begin
      r_seen <= 1'b1;
      r_cnt  <= (&w_cnt_b) ? w_cnt_b : w_cnt_b + 1'b1;
      if (w_first) begin
        r_minx <= i_x;
        r_maxx <= i_x;
        r_miny <= i_y;
        r_maxy <= i_y;
      end else begin
        if (i_x < r_minx) r_minx <= i_x;
        if (i_x > r_maxx) r_maxx <= i_x;
        if (i_y < r_miny) r_miny <= i_y;
        if (i_y > r_maxy) r_maxy <= i_y;
      end
    end else if (i_clr) begin
      r_seen <= 1'b0;
      r_cnt  <= '0;
      r_minx <= '0;
      r_maxx <= '0;
      r_miny <= '0;
      r_maxy <= '0;
    end
  end

  // Published results; unseen targets carry zeros because cleared accumulators are zero.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      o_min_x <= '0;
      o_max_x <= '0;
      o_min_y <= '0;
      o_max_y <= '0;
      o_count <= '0;
      o_valid <= 1'b0;
    end else if (i_latch) begin
      o_min_x <= r_minx;
      o_max_x <= r_maxx;
      o_min_y <= r_miny;
      o_max_y <= r_maxy;
      o_count <= r_cnt;
      o_valid <= r_seen;
    end
  end

  assign o_perim = o_valid &&
    (((i_x == o_min_x || i_x == o_max_x) && i_y >= o_min_y && i_y <= o_max_y) ||
     ((i_y == o_min_y || i_y == o_max_y) && i_x >= o_min_x && i_x <= o_max_x));
endmodule

module block_detector_stream #(
  parameter int PIX_W       = 24,
  parameter int NUM_TARGETS = 2,
  parameter int COORD_W     = 12,
  parameter int CNT_W       = 20
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [PIX_W-1:0]               s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tuser,
  input  logic                           s_axis_tlast,
  output logic [PIX_W-1:0]               m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tuser,
  output logic                           m_axis_tlast,
  input  logic [COORD_W-1:0]             cfg_height,
  input  logic [NUM_TARGETS*PIX_W-1:0]   cfg_lo,
  input  logic [NUM_TARGETS*PIX_W-1:0]   cfg_hi,
  input  logic                           cfg_overlay_en,
  input  logic [PIX_W-1:0]               cfg_overlay_color,
  output logic [NUM_TARGETS*COORD_W-1:0] box_min_x,
  output logic [NUM_TARGETS*COORD_W-1:0] box_max_x,
  output logic [NUM_TARGETS*COORD_W-1:0] box_min_y,
  output logic [NUM_TARGETS*COORD_W-1:0] box_max_y,
  output logic [NUM_TARGETS*CNT_W-1:0]   box_count,
  output logic [NUM_TARGETS-1:0]         box_valid,
  output logic                           frame_done
);
  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                 r_state, w_next;
  logic                   w_acc, w_upd, w_eof, w_clr;
  logic [COORD_W-1:0]     r_x, r_y, w_cur_x, w_cur_y;
  logic                   r_pend, r_done;
  logic [NUM_TARGETS-1:0] w_perim;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign w_acc   = s_axis_tvalid && s_axis_tready;
  assign w_cur_x = s_axis_tuser ? '0 : r_x;
  assign w_cur_y = s_axis_tuser ? '0 : r_y;

  // Position of the next pixel; x and y saturate at all-ones.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_acc) begin
      if (s_axis_tlast) begin
        r_x <= '0;
        r_y <= (&w_cur_y) ? w_cur_y : w_cur_y + 1'b1;
      end else begin
        r_x <= (&w_cur_x) ? w_cur_x : w_cur_x + 1'b1;
        r_y <= w_cur_y;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state: SOF opens a frame, the last beat of the last line closes it.
  always_comb begin
    w_next = r_state;
    if (w_acc && (r_state == S_ACTIVE || s_axis_tuser))
      w_next = (s_axis_tlast && w_cur_y == cfg_height - 1'b1) ? S_IDLE : S_ACTIVE;
  end

  // Frame control: which beats accumulate, frame end, and accumulator clearing.
  always_comb begin
    w_upd = w_acc && (r_state == S_ACTIVE || s_axis_tuser);
    w_eof = w_upd && s_axis_tlast && (w_cur_y == cfg_height - 1'b1);
    w_clr = r_pend || (w_acc && s_axis_tuser);
  end

  // Results publish one cycle after the frame-ending beat.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_pend <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_pend <= w_eof;
      r_done <= r_pend;
    end
  end
  assign frame_done = r_done;

  for (genvar t = 0; t < NUM_TARGETS; t++) begin : g_tgt
    block_detector_target #(.PIX_W(PIX_W), .COORD_W(COORD_W), .CNT_W(CNT_W)) u_tgt (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .i_pix   (s_axis_tdata),
      .i_lo    (cfg_lo[t*PIX_W +: PIX_W]),
      .i_hi    (cfg_hi[t*PIX_W +: PIX_W]),
      .i_x     (w_cur_x),
      .i_y     (w_cur_y),
      .i_upd   (w_upd),
      .i_clr   (w_clr),
      .i_latch (r_pend),
      .o_min_x (box_min_x[t*COORD_W +: COORD_W]),
      .o_max_x (box_max_x[t*COORD_W +: COORD_W]),
      .o_min_y (box_min_y[t*COORD_W +: COORD_W]),
      .o_max_y (box_max_y[t*COORD_W +: COORD_W]),
      .o_count (box_count[t*CNT_W +: CNT_W]),
      .o_valid (box_valid[t]),
      .o_perim (w_perim[t])
    );
  end

  // Single output register stage; overlay decided on the input beat.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (s_axis_tready) begin
      m_axis_tvalid <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        m_axis_tdata <= (cfg_overlay_en && |w_perim) ? cfg_overlay_color : s_axis_tdata;
        m_axis_tuser <= s_axis_tuser;
        m_axis_tlast <= s_axis_tlast;
      end
    end
  end
endmodule

// File: doc/block_detector_stream.md
Name: block_detector_stream

Overview:
- Streaming colour-blob detector for the filter video path; sits between the video DMA/AXI4-Stream source and the overlay/output stage.
- Inspects every RGB pixel against NUM_TARGETS programmable colour windows and tracks, per target, the bounding box and hit count over one frame. Publishes the results at end of frame.
- Optionally draws the previous frame's boxes onto the passed-through video.

Parameters:
- PIX_W, 24: pixel width; three equal components of PIX_W/3 bits (R=[23:16], G=[15:8], B=[7:0]).
- NUM_TARGETS, 2: number of independent colour windows and trackers.
- COORD_W, 12: width of the x/y counters and box coordinates.
- CNT_W, 20: width of the per-target hit counter.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  PIX_W  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tuser  in  1  start of frame (first pixel).
- s_axis_tlast  in  1  end of line.
- m_axis_tdata  out  PIX_W  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tuser  out  1  forwarded SOF.
- m_axis_tlast  out  1  forwarded EOL.
- cfg_height  in  COORD_W  lines per frame.
- cfg_lo  in  NUM_TARGETS*PIX_W  per-target inclusive lower bound, per component.
- cfg_hi  in  NUM_TARGETS*PIX_W  per-target inclusive upper bound, per component.
- cfg_overlay_en  in  1  enable box drawing.
- cfg_overlay_color  in  PIX_W  colour used for box pixels.
- box_min_x, box_max_x, box_min_y, box_max_y  out  NUM_TARGETS*COORD_W each  latched box per target.
- box_count  out  NUM_TARGETS*CNT_W  latched hit count per target.
- box_valid  out  NUM_TARGETS  latched box holds at least one hit.
- frame_done  out  1  one-cycle pulse when results are updated.

Behaviour:
- Reset values: all outputs 0 (m_axis_tvalid=0, box_*=0, box_valid=0, frame_done=0). Counters and accumulators also reset to 0; the FSM resets to IDLE.

Handshake and latency:
- A beat is accepted when s_axis_tvalid && s_axis_tready.
- Output is a single register stage with latency 1. s_axis_tready = !m_axis_tvalid || m_axis_tready.
- m_axis_* holds stable while m_axis_tvalid && !m_axis_tready.
- tuser and tlast pass through unchanged, aligned with their pixel.

Position tracking:
- An accepted beat with tuser sets x=0, y=0 for that pixel.
- Otherwise x increments per beat. After a tlast beat, x=0 and y increments.
- x and y saturate at 2^COORD_W-1.

FSM:
- IDLE: drops beats until tuser, then enters ACTIVE.
- ACTIVE: a tuser beat mid-frame discards the partial accumulators, restarts at (0,0), and produces no frame_done.
- A tlast beat with y==cfg_height-1 ends the frame and goes to IDLE.
- A beat arriving in IDLE without tuser is still forwarded but not accumulated.

Matching:
- A pixel hits target t when, for every component c, cfg_lo[t].c <= pix.c <= cfg_hi[t].c (unsigned).
- If lo>hi for any component, target t never matches.

Accumulation:
- Each target keeps running min/max of x and y over hit pixels, a hit count (saturating at 2^CNT_W-1) and a seen flag.
- The first hit of a frame loads min=max=current coordinate.
- All targets update in parallel on the same beat.

End of frame:
- On the cycle after the frame-ending beat, box_* and box_count are loaded from the accumulators, box_valid=seen, and frame_done pulses for 1 cycle.
- Accumulators clear at the same time.
- Targets with no hit output box coordinates 0, count 0, box_valid=0.
- If a tuser beat is accepted in the same cycle as the result update, the update takes priority and the new frame's first pixel is still accumulated.

Overlay:
- Uses the latched box_* values (previous frame).
- When cfg_overlay_en=1 and the pixel lies on the perimeter of any target with box_valid=1, m_axis_tdata=cfg_overlay_color.
- Perimeter test: x∈{min_x,max_x} with min_y<=y<=max_y, or y∈{min_y,max_y} with min_x<=x<=max_x.
- Otherwise the input pixel passes through. The overlay decision is made on the input beat and registered with it.

Configuration:
- cfg_* inputs are sampled every beat; software changes them only between frames. Behaviour after a mid-frame change is undefined.

Reset mid-operation:
- Asserting ARESET immediately clears everything: the partial frame is lost, the output beat is dropped, and box_* return to 0.

Test Plan:
- Reset/idle: hold ARESET 5 cycles -> all outputs 0; after release with no input, m_axis_tvalid stays 0 and frame_done never pulses.
- Single blob: 8x4 frame (cfg_height=4), all pixels 0x000000 except 0xFF0000 at (2,1),(5,2); target0 lo=0xC00000, hi=0xFF3F3F -> frame_done once, box0=(2..5,1..2), count0=2, box_valid=01.
- Overlay: second identical frame, cfg_overlay_en=1, colour 0x00FF00 -> output pixels (2..5,1),(2..5,2),(2,*),(5,*) in rows 1..2 equal 0x00FF00; all others unchanged.
- Backpressure: random m_axis_tready at 50% over the 8x4 frame -> output pixel sequence identical to the no-stall run, no beat lost or duplicated, results unchanged.
- Aborted frame: tuser reasserted at (3,2) of a frame -> no frame_done for the partial frame; the following full frame reports only its own hits.
- Two targets and no-match: target1 lo=0x010101, hi=0x000000 -> box_valid[1]=0 and box1 fields 0, while target0 reports normally; hit count saturation checked with CNT_W=4 and 20 hits -> count=15.
